// File: rtl/prbs7_lane_checker.sv
// Per-lane PRBS-7 (x^7 + x^6 + 1) receive checker.
// Self-synchronising: every received bit is predicted from the received
// stream itself (b[n] = b[n-6] ^ b[n-7]), so no seed alignment is needed.
// Produces lock status, an error strobe, a saturating error count and a
// steady LED bit that drops for LED_HOLD cycles after any locked error.
module prbs7_lane_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16,
    parameter int LED_HOLD = 4_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      rx_data,
    input  logic             rx_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             led_ok
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
    localparam int TW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;

    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(LED_HOLD - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_reg;
    logic [6:0]        history_reg;
    logic              prime_reg;
    logic [GW-1:0]     good_cnt_reg;
    logic [BW-1:0]     bad_cnt_reg;
    logic [TW-1:0]     timer_reg;
    logic [ERR_W-1:0]  err_count_reg;
    logic              locked_reg;
    logic              err_pulse_reg;
    logic              led_ok_reg;

    // Bit stream as seen by the predictor: oldest history bit at index 0,
    // newest received bit (rx_data[15]) at index 22.
    logic [22:0] stream;
    logic [15:0] mismatch;
    logic        word_err;
    logic        err_hit;
    logic        lock_gain;
    logic        lock_loss;
    logic        locked_next;

    assign stream = {rx_data, history_reg};

    // One predictor per bit lane; each bit depends only on bits 6 and 7 back.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pred
            assign mismatch[gi] = stream[gi + 7] ^ stream[gi + 1] ^ stream[gi];
        end
    endgenerate

    // The all-zero word self-predicts perfectly, so it is flagged explicitly.
    assign word_err = (|mismatch) || (rx_data == 16'h0000);

    // Decode the events that drive state and outputs for this cycle.
    always_comb begin
        err_hit     = rx_valid && (state_reg == LOCKED) && word_err;
        lock_gain   = rx_valid && (state_reg == HUNT) && !prime_reg && !word_err
                      && (good_cnt_reg == LOCK_LAST);
        lock_loss   = err_hit && (bad_cnt_reg == LOSS_LAST);
        locked_next = ((state_reg == LOCKED) && !lock_loss) || lock_gain;
    end

    // Lock FSM with its history, prime flag and good/bad run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= HUNT;
            history_reg  <= 7'd0;
            prime_reg    <= 1'b1;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
        end else if (rx_valid) begin
            history_reg <= rx_data[15:9];
            case (state_reg)
                HUNT: begin
                    if (prime_reg) begin
                        prime_reg <= 1'b0;
                    end else if (word_err) begin
                        good_cnt_reg <= '0;
                    end else begin
                        good_cnt_reg <= good_cnt_reg + GW'(1);
                        if (good_cnt_reg == LOCK_LAST) begin
                            state_reg   <= LOCKED;
                            bad_cnt_reg <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (word_err) begin
                        bad_cnt_reg <= bad_cnt_reg + BW'(1);
                        if (bad_cnt_reg == LOSS_LAST) begin
                            state_reg    <= HUNT;
                            good_cnt_reg <= '0;
                            prime_reg    <= 1'b1;
                        end
                    end else begin
                        bad_cnt_reg <= '0;
                    end
                end
                default: state_reg <= HUNT;
            endcase
        end
    end

    // Error counter, LED hold timer and registered status outputs.
    // led_ok uses the timer value held during the word's own cycle, so the
    // LED stays dark for the errored cycle plus LED_HOLD-1 further cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= '0;
            timer_reg     <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            led_ok_reg    <= 1'b0;
        end else begin
            locked_reg    <= locked_next;
            err_pulse_reg <= err_hit;
            led_ok_reg    <= locked_next && (clear || (!err_hit && timer_reg == '0));

            if (clear) begin
                err_count_reg <= '0;
            end else if (err_hit && (err_count_reg != {ERR_W{1'b1}})) begin
                err_count_reg <= err_count_reg + ERR_W'(1);
            end

            if (clear) begin
                timer_reg <= '0;
            end else if (err_hit) begin
                timer_reg <= HOLD_LOAD;
            end else if (timer_reg != '0) begin
                timer_reg <= timer_reg - TW'(1);
            end
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign led_ok    = led_ok_reg;

endmodule

// File: tb/tb_prbs7_lane_checker.sv
// Directed bench for prbs7_lane_checker. Two instances share the stimulus:
// one with a 16-bit error counter, one with a 4-bit counter for saturation.
// Expected outputs come from a bit-serial reference model, pushed to a
// scoreboard queue when a word is driven and popped after the clock edge.
module tb_prbs7_lane_checker;

    localparam int LH = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        clear;

    logic        locked_a, err_pulse_a, led_ok_a;
    logic [15:0] err_count_a;
    logic        locked_b, err_pulse_b, led_ok_b;
    logic [3:0]  err_count_b;

    always #5 clk = ~clk;

    prbs7_lane_checker #(
        .LOCK_CNT(16), .LOSS_CNT(4), .ERR_W(16), .LED_HOLD(LH)
    ) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .locked(locked_a), .err_pulse(err_pulse_a),
        .err_count(err_count_a), .led_ok(led_ok_a)
    );

    prbs7_lane_checker #(
        .LOCK_CNT(16), .LOSS_CNT(4), .ERR_W(4), .LED_HOLD(LH)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .locked(locked_b), .err_pulse(err_pulse_b),
        .err_count(err_count_b), .led_ok(led_ok_b)
    );

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic        led;
        logic [15:0] cnt_a;
        logic [3:0]  cnt_b;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_step = 0;

    // reference model state
    logic       m_locked, m_prime;
    int         m_good, m_bad, m_cnt, m_cnt4, m_timer;
    logic [6:0] m_sr;     // m_sr[0] = newest received bit
    logic [6:0] g;        // stimulus generator, g[0] = newest bit

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, n_step);
        end
    endtask

    task automatic gen_word(output logic [15:0] w);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b = g[5] ^ g[6];
            w[i] = b;
            g = {g[5:0], b};
        end
    endtask

    task automatic model(input logic rst, input logic v, input logic clr,
                         input logic [15:0] d, output exp_t e);
        logic       err, hit;
        logic [6:0] sr;
        int         old_t;
        hit = 1'b0;
        err = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_prime = 1'b1; m_good = 0; m_bad = 0;
            m_cnt = 0; m_cnt4 = 0; m_timer = 0; m_sr = 7'd0;
            e = '0;
            return;
        end
        old_t = m_timer;
        if (v) begin
            sr  = m_sr;
            err = (d == 16'h0000);
            for (int i = 0; i < 16; i++) begin
                if (d[i] != (sr[5] ^ sr[6])) err = 1'b1;
                sr = {sr[5:0], d[i]};
            end
            m_sr = sr;
            if (!m_locked) begin
                if (m_prime) m_prime = 1'b0;
                else if (err) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == 16) begin m_locked = 1'b1; m_bad = 0; end
                end
            end else if (err) begin
                hit = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
                m_bad++;
                if (m_bad == 4) begin m_locked = 1'b0; m_good = 0; m_prime = 1'b1; end
            end else begin
                m_bad = 0;
            end
        end
        if (hit) m_timer = LH - 1;
        else if (m_timer > 0) m_timer--;
        if (clr) begin m_cnt = 0; m_cnt4 = 0; m_timer = 0; end
        e.locked = m_locked;
        e.pulse  = hit;
        e.cnt_a  = 16'(m_cnt);
        e.cnt_b  = 4'(m_cnt4);
        e.led    = m_locked && (clr || (!hit && old_t == 0));
    endtask

    task automatic step(input logic rst, input logic v, input logic clr, input logic [15:0] d);
        exp_t e, got;
        reset = rst; rx_valid = v; clear = clr; rx_data = d;
        model(rst, v, clr, d, e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        got = sbq.pop_front();
        chk("sb_locked_a", 32'(locked_a), 32'(got.locked));
        chk("sb_locked_b", 32'(locked_b), 32'(got.locked));
        chk("sb_pulse_a", 32'(err_pulse_a), 32'(got.pulse));
        chk("sb_pulse_b", 32'(err_pulse_b), 32'(got.pulse));
        chk("sb_cnt_a", 32'(err_count_a), 32'(got.cnt_a));
        chk("sb_cnt_b", 32'(err_count_b), 32'(got.cnt_b));
        chk("sb_led_a", 32'(led_ok_a), 32'(got.led));
        chk("sb_led_b", 32'(led_ok_b), 32'(got.led));
        $display("step %0d rst=%b v=%b clr=%b d=%h -> locked=%b pulse=%b cnt=%0d cnt4=%0d led=%b",
                 n_step, rst, v, clr, d, locked_a, err_pulse_a, err_count_a, err_count_b, led_ok_a);
    endtask

    task automatic clean(input logic clr);
        logic [15:0] w;
        gen_word(w);
        step(1'b0, 1'b1, clr, w);
    endtask

    task automatic bad_word(input logic clr);
        logic [15:0] w;
        gen_word(w);
        step(1'b0, 1'b1, clr, w ^ 16'h0020);
    endtask

    initial begin
        int nv;
        reset = 1'b1; rx_valid = 1'b0; clear = 1'b0; rx_data = 16'h0000;
        g = 7'h7F;
        m_locked = 1'b0; m_prime = 1'b1; m_good = 0; m_bad = 0;
        m_cnt = 0; m_cnt4 = 0; m_timer = 0; m_sr = 7'd0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 16'h1234);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_pulse", 32'(err_pulse_a), 32'd0);
        chk("rst_cnt", 32'(err_count_a), 32'd0);
        chk("rst_led", 32'(led_ok_a), 32'd0);

        // lock on continuous clean PRBS: locked the cycle after word 17
        for (int k = 1; k <= 17; k++) begin
            clean(1'b0);
            chk("lock_time", 32'(locked_a), 32'(k == 17));
            chk("lock_led", 32'(led_ok_a), 32'(k == 17));
            chk("lock_cnt", 32'(err_count_a), 32'd0);
        end
        for (int k = 0; k < 5; k++) clean(1'b0);

        // single bit-5 error: one pulse, count 1, LED dark for LH cycles
        bad_word(1'b0);
        chk("single_pulse", 32'(err_pulse_a), 32'd1);
        chk("single_cnt", 32'(err_count_a), 32'd1);
        chk("single_locked", 32'(locked_a), 32'd1);
        chk("single_led", 32'(led_ok_a), 32'd0);
        for (int k = 1; k <= LH; k++) begin
            clean(1'b0);
            chk("hold_led", 32'(led_ok_a), 32'(k == LH));
            chk("hold_pulse", 32'(err_pulse_a), 32'd0);
            chk("hold_locked", 32'(locked_a), 32'd1);
        end

        // clear, then four all-zero words drop lock on the 4th
        clean(1'b1);
        chk("clear_cnt", 32'(err_count_a), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            chk("zero_cnt", 32'(err_count_a), 32'(k));
            chk("zero_pulse", 32'(err_pulse_a), 32'd1);
            chk("zero_locked", 32'(locked_a), 32'(k < 4));
        end
        for (int k = 1; k <= 17; k++) begin
            clean(1'b0);
            chk("relock_time", 32'(locked_a), 32'(k == 17));
            chk("relock_cnt", 32'(err_count_a), 32'd4);
        end

        // saturation of the 4-bit counter
        clean(1'b1);
        for (int k = 1; k <= 20; k++) begin
            bad_word(1'b0);
            chk("sat_cnt_b", 32'(err_count_b), 32'((k > 15) ? 15 : k));
            chk("sat_pulse", 32'(err_pulse_b), 32'd1);
            clean(1'b0);
        end
        chk("sat_cnt_a", 32'(err_count_a), 32'd20);
        chk("sat_locked", 32'(locked_b), 32'd1);

        // clear coincident with an errored word: clear wins, pulse still fires
        bad_word(1'b1);
        chk("clrerr_cnt_a", 32'(err_count_a), 32'd0);
        chk("clrerr_cnt_b", 32'(err_count_b), 32'd0);
        chk("clrerr_pulse", 32'(err_pulse_a), 32'd1);
        chk("clrerr_led", 32'(led_ok_a), 32'd1);

        // build up count 7, then a one-cycle reset mid-stream
        for (int k = 0; k < 7; k++) begin
            bad_word(1'b0);
            clean(1'b0);
        end
        chk("pre_rst_cnt", 32'(err_count_a), 32'd7);
        chk("pre_rst_locked", 32'(locked_a), 32'd1);
        begin
            logic [15:0] w;
            gen_word(w);
            step(1'b1, 1'b1, 1'b0, w);
        end
        chk("mid_rst_locked", 32'(locked_a), 32'd0);
        chk("mid_rst_cnt", 32'(err_count_a), 32'd0);
        chk("mid_rst_led", 32'(led_ok_a), 32'd0);
        chk("mid_rst_pulse", 32'(err_pulse_a), 32'd0);

        // relock with rx_valid toggling 1010...: 17 valid words needed
        nv = 0;
        for (int k = 0; k < 36; k++) begin
            if ((k % 2) == 0) begin
                clean(1'b0);
                nv++;
            end else begin
                step(1'b0, 1'b0, 1'b0, 16'($urandom));
            end
            chk("gap_lock", 32'(locked_a), 32'(nv >= 17));
            chk("gap_cnt", 32'(err_count_a), 32'd0);
        end

        // idle gap while locked leaves lock untouched
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            chk("idle_locked", 32'(locked_a), 32'd1);
            chk("idle_pulse", 32'(err_pulse_a), 32'd0);
        end
        clean(1'b0);
        chk("idle_resume", 32'(locked_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
